// File: rtl/seu_cnt_pkg.sv
// Shared definitions for the multi-channel SEU event counter: channel FSM encoding
// and small helpers for select-width sizing and 2-of-3 voting.
package seu_cnt_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Callers zero-extend narrower fields to 32 bits and truncate the result.
  function automatic logic [31:0] vote3(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/seu_cnt_channel.sv
// One SEU channel: event FSM with holdoff, saturating/wrapping counter and sticky overflow.
// SEU_CNT_TMR_EN triplicates counter, overflow and FSM state with voted feedback.
module seu_cnt_channel
  import seu_cnt_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int HOLD_W   = 4,
  parameter int SAT_MODE = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              err,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              clr,
  output logic [CNT_W-1:0]  cnt,
  output logic              ovf
`ifdef SEU_CNT_TMR_EN
  ,
  output logic              tmr_err
`endif
);

  logic [1:0]        state_c, state_d;
  logic [CNT_W-1:0]  cnt_c, cnt_d;
  logic              ovf_c, ovf_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              inc_s;

  // Event FSM: only the IDLE->ACTIVE transition produces a count.
  always_comb begin
    state_d = state_c;
    hcnt_d  = hcnt_q;
    inc_s   = 1'b0;
    case (state_c)
      ST_IDLE: begin
        if (err) begin
          inc_s   = 1'b1;
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (err) begin
          state_d = ST_ACTIVE;
        end else if (holdoff == {HOLD_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d  = holdoff;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (err) begin
          state_d = ST_ACTIVE;
        end else if (hcnt_q <= HOLD_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // Counter update; clear beats a simultaneous increment.
  always_comb begin
    cnt_d = cnt_c;
    ovf_d = ovf_c;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (inc_s) begin
      if (cnt_c == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
        cnt_d = (SAT_MODE != 0) ? cnt_c : {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_c + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_c;
    end
  end

  // Holdoff counter is not part of the protected state.
  always_ff @(posedge clk or posedge res) begin
    if (res) hcnt_q <= {HOLD_W{1'b0}};
    else     hcnt_q <= hcnt_d;
  end

`ifdef SEU_CNT_TMR_EN
  logic [1:0]       state_q [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic             ovf_q   [3];
  logic             tmr_err_q;
  logic             mismatch_s;

  assign state_c = 2'(vote3(32'(state_q[0]), 32'(state_q[1]), 32'(state_q[2])));
  assign cnt_c   = CNT_W'(vote3(32'(cnt_q[0]), 32'(cnt_q[1]), 32'(cnt_q[2])));
  assign ovf_c   = 1'(vote3(32'(ovf_q[0]), 32'(ovf_q[1]), 32'(ovf_q[2])));

  assign mismatch_s = (state_q[0] != state_q[1]) | (state_q[0] != state_q[2]) |
                      (cnt_q[0]   != cnt_q[1])   | (cnt_q[0]   != cnt_q[2])   |
                      (ovf_q[0]   != ovf_q[1])   | (ovf_q[0]   != ovf_q[2]);

  // All three copies reload from the voted next state, scrubbing a single upset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= {CNT_W{1'b0}};
        ovf_q[k]   <= 1'b0;
      end
      tmr_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d;
        cnt_q[k]   <= cnt_d;
        ovf_q[k]   <= ovf_d;
      end
      tmr_err_q <= mismatch_s;
    end
  end

  assign tmr_err = tmr_err_q;
`else
  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  assign state_c = state_q;
  assign cnt_c   = cnt_q;
  assign ovf_c   = ovf_q;

  // Single-copy channel state.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
`endif

  assign cnt = cnt_c;
  assign ovf = ovf_c;

endmodule

// File: rtl/seu_event_counter_multi.sv
// N_CH-channel SEU event counter with snapshot/clear readout and registered any_err.
// SEU_CNT_TMR_EN adds triplicated channel state and the tmr_err output.
module seu_event_counter_multi
  import seu_cnt_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int HOLD_W   = 4,
  parameter int SAT_MODE = 1
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [N_CH-1:0]              err,
  input  logic [HOLD_W-1:0]            holdoff,
  input  logic [N_CH-1:0]              clear,
  input  logic                         rd_req,
  input  logic [clog2_min1(N_CH)-1:0]  rd_sel,
  input  logic                         rd_clr,
  output logic                         rd_ack,
  output logic [CNT_W-1:0]             rd_data,
  output logic                         rd_ovf,
  output logic [N_CH-1:0]              ovf,
  output logic                         any_err
`ifdef SEU_CNT_TMR_EN
  ,
  output logic [N_CH-1:0]              tmr_err
`endif
);

  localparam int SEL_W = clog2_min1(N_CH);

  logic [CNT_W-1:0] cnt_s [N_CH];
  logic [N_CH-1:0]  clr_s;
  logic [CNT_W-1:0] sel_cnt_s;
  logic             sel_ovf_s;
  logic             rd_ack_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_ovf_q;
  logic             any_err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // A read-clear hits the selected channel on the same edge as the snapshot.
    assign clr_s[g] = clear[g] | (rd_req & rd_clr & (rd_sel == SEL_W'(g)));

    seu_cnt_channel #(
      .CNT_W    (CNT_W),
      .HOLD_W   (HOLD_W),
      .SAT_MODE (SAT_MODE)
    ) u_ch (
      .clk     (clk),
      .res     (res),
      .err     (err[g]),
      .holdoff (holdoff),
      .clr     (clr_s[g]),
      .cnt     (cnt_s[g]),
      .ovf     (ovf[g])
`ifdef SEU_CNT_TMR_EN
      ,
      .tmr_err (tmr_err[g])
`endif
    );
  end

  // One-hot AND-OR mux; an out-of-range select yields zero.
  always_comb begin
    sel_cnt_s = {CNT_W{1'b0}};
    sel_ovf_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      sel_cnt_s = sel_cnt_s | (cnt_s[i] & {CNT_W{rd_sel == SEL_W'(i)}});
      sel_ovf_s = sel_ovf_s | (ovf[i] & (rd_sel == SEL_W'(i)));
    end
  end

  // Snapshot registers hold between requests; any_err is a plain 1-cycle delay.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= {CNT_W{1'b0}};
      rd_ovf_q  <= 1'b0;
      any_err_q <= 1'b0;
    end else begin
      rd_ack_q  <= rd_req;
      if (rd_req) begin
        rd_data_q <= sel_cnt_s;
        rd_ovf_q  <= sel_ovf_s;
      end
      any_err_q <= |err;
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign rd_ovf  = rd_ovf_q;
  assign any_err = any_err_q;

endmodule

// File: tb/tb_seu_event_counter_multi.sv
// Directed bench: one saturating and one wrapping instance (5 channels, 4-bit counters)
// driven in lockstep; results are observed through the readout port and live flags.
module tb_seu_event_counter_multi;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [4:0] err = 5'd0;
  logic [3:0] holdoff = 4'd0;
  logic [4:0] clear = 5'd0;
  logic       rd_req = 1'b0;
  logic [2:0] rd_sel = 3'd0;
  logic       rd_clr = 1'b0;

  logic       rd_ack_s, rd_ovf_s, any_err_s;
  logic [3:0] rd_data_s;
  logic [4:0] ovf_s;
  logic       rd_ack_w, rd_ovf_w, any_err_w;
  logic [3:0] rd_data_w;
  logic [4:0] ovf_w;
`ifdef SEU_CNT_TMR_EN
  logic [4:0] tmr_err_s, tmr_err_w;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  seu_event_counter_multi #(.N_CH(5), .CNT_W(4), .HOLD_W(4), .SAT_MODE(1)) u_dut_sat (
    .clk(clk), .res(res), .err(err), .holdoff(holdoff), .clear(clear),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_clr(rd_clr),
    .rd_ack(rd_ack_s), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s),
    .ovf(ovf_s), .any_err(any_err_s)
`ifdef SEU_CNT_TMR_EN
    , .tmr_err(tmr_err_s)
`endif
  );

  seu_event_counter_multi #(.N_CH(5), .CNT_W(4), .HOLD_W(4), .SAT_MODE(0)) u_dut_wrap (
    .clk(clk), .res(res), .err(err), .holdoff(holdoff), .clear(clear),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_clr(rd_clr),
    .rd_ack(rd_ack_w), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w),
    .ovf(ovf_w), .any_err(any_err_w)
`ifdef SEU_CNT_TMR_EN
    , .tmr_err(tmr_err_w)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int ch, input int n);
    repeat (n) begin
      err[ch] = 1'b1;
      tick();
      err[ch] = 1'b0;
      tick();
    end
  endtask

  task automatic rd(input logic [2:0] sel, input logic clr,
                    input logic [3:0] exp_s, input logic [3:0] exp_w,
                    input logic eo_s, input logic eo_w, input string tag);
    rd_req = 1'b1;
    rd_sel = sel;
    rd_clr = clr;
    tick();
    rd_req = 1'b0;
    rd_clr = 1'b0;
    check({tag, "_ack_sat"},  32'(rd_ack_s),  32'd1);
    check({tag, "_ack_wrap"}, 32'(rd_ack_w),  32'd1);
    check({tag, "_data_sat"}, 32'(rd_data_s), 32'(exp_s));
    check({tag, "_data_wrap"},32'(rd_data_w), 32'(exp_w));
    check({tag, "_ovf_sat"},  32'(rd_ovf_s),  32'(eo_s));
    check({tag, "_ovf_wrap"}, 32'(rd_ovf_w),  32'(eo_w));
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_ack",     32'(rd_ack_s),  32'd0);
    check("rst_data",    32'(rd_data_s), 32'd0);
    check("rst_rdovf",   32'(rd_ovf_s),  32'd0);
    check("rst_ovf_sat", 32'(ovf_s),     32'd0);
    check("rst_ovf_wrap",32'(ovf_w),     32'd0);
    check("rst_anyerr",  32'(any_err_s), 32'd0);
    res = 1'b0;
    tick();

    // Single-cycle pulse on ch0, holdoff 0
    err = 5'b00001;
    tick();
    err = 5'b00000;
    check("pulse_anyerr", 32'(any_err_s), 32'd1);
    tick();
    rd(3'd0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, "pulse_ch0");
    rd(3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "pulse_ch1");

    // 100-cycle burst on ch1 counts once
    err = 5'b00010;
    repeat (100) tick();
    check("burst_anyerr_hi", 32'(any_err_w), 32'd1);
    err = 5'b00000;
    tick();
    check("burst_anyerr_lo", 32'(any_err_w), 32'd0);
    rd(3'd1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, "burst_ch1");

    // Toggle 1,0,0,1 with holdoff 3: re-entry during HOLD extends the event
    holdoff = 4'd3;
    clear = 5'b00010;
    tick();
    clear = 5'b00000;
    err[1] = 1'b1; tick();
    err[1] = 1'b0; tick();
    tick();
    err[1] = 1'b1; tick();
    err[1] = 1'b0;
    repeat (5) tick();
    rd(3'd1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, "hold3_ch1");

    // Same pattern with holdoff 1: second rise counts
    holdoff = 4'd1;
    clear = 5'b00010;
    tick();
    clear = 5'b00000;
    err[1] = 1'b1; tick();
    err[1] = 1'b0; tick();
    tick();
    err[1] = 1'b1; tick();
    err[1] = 1'b0;
    repeat (3) tick();
    rd(3'd1, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0, "hold1_ch1");
    holdoff = 4'd0;
    tick();

    // 17 events on ch2: saturate vs wrap
    pulses(2, 15);
    check("ch2_15_ovf_sat",  32'(ovf_s), 32'd0);
    check("ch2_15_ovf_wrap", 32'(ovf_w), 32'd0);
    pulses(2, 2);
    check("ch2_17_ovf_sat",  32'(ovf_s), 32'h04);
    check("ch2_17_ovf_wrap", 32'(ovf_w), 32'h04);
    rd(3'd2, 1'b0, 4'd15, 4'd1, 1'b1, 1'b1, "ch2_17");

    // Clear beats a simultaneous increment; held err is not re-counted
    clear = 5'b00100;
    err = 5'b00100;
    tick();
    clear = 5'b00000;
    tick();
    err = 5'b00000;
    tick();
    check("clr_ovf_sat",  32'(ovf_s), 32'd0);
    check("clr_ovf_wrap", 32'(ovf_w), 32'd0);
    rd(3'd2, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "clr_ch2");

    // Read-clear race on ch3: snapshot 7, increment lost
    pulses(3, 7);
    err = 5'b01000;
    rd(3'd3, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, "race_ch3");
    err = 5'b00000;
    tick();
    check("race_ack_drop", 32'(rd_ack_s), 32'd0);
    rd(3'd3, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "race_after");

    // Out-of-range select with rd_clr: ack, zero data, nothing cleared
    rd(3'd5, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "oor");

    // Back-to-back requests, then data holds
    rd_req = 1'b1;
    rd_sel = 3'd0;
    tick();
    check("b2b0_ack",  32'(rd_ack_s),  32'd1);
    check("b2b0_data", 32'(rd_data_s), 32'd1);
    rd_sel = 3'd1;
    tick();
    rd_req = 1'b0;
    check("b2b1_ack",  32'(rd_ack_w),  32'd1);
    check("b2b1_data", 32'(rd_data_w), 32'd2);
    tick();
    check("hold_ack",  32'(rd_ack_s),  32'd0);
    check("hold_data", 32'(rd_data_s), 32'd2);

    // Async reset while ch0 is in HOLD with count 5
    clear = 5'b00001;
    tick();
    clear = 5'b00000;
    pulses(0, 4);
    holdoff = 4'd3;
    err = 5'b00001;
    tick();
    err = 5'b10000;
    tick();
    check("prerst_anyerr", 32'(any_err_s), 32'd1);
    check("prerst_data",   32'(rd_data_s), 32'd2);
    #2;
    res = 1'b1;
    #1;
    check("midrst_anyerr", 32'(any_err_s), 32'd0);
    check("midrst_data",   32'(rd_data_s), 32'd0);
    check("midrst_rdovf",  32'(rd_ovf_w),  32'd0);
    check("midrst_ack",    32'(rd_ack_w),  32'd0);
    check("midrst_ovf",    32'(ovf_s),     32'd0);
    err = 5'b00000;
    tick();
    res = 1'b0;
    holdoff = 4'd0;
    tick();
    rd(3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "postrst_ch0");
    pulses(0, 1);
    rd(3'd0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, "postrst_pulse");
    rd(3'd4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "postrst_ch4");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
